dcache_responder: RTL and testbench
===================================

# dcache_responder

Memory-side responder for the data-cache request stream driven by the data cache generator and by the pipeline's MEM stage. Accepts one read and/or write per cycle on `mem_read`/`mem_write`/`address`/`writedata` and services it from a small direct-mapped, write-back, write-allocate cache. On a miss it raises `requested_data_to_mem` to stall the requester, evicts any dirty victim, refills the line over a req/ack main-memory port, then completes the latched request.

## Interface
- `LINES`, 4: number of cache lines. Power of 2, ≥2.
- Line size is fixed at 4 words (128 bit). Address fields: `[1:0]` ignored, `[3:2]` word, `[3+log2(LINES):4]` index, remaining upper bits tag.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `mem_read` input 1: read request, sampled only in IDLE.
- `mem_write` input 1: write request, sampled only in IDLE.
- `address` input 32: byte address of the request.
- `writedata` input 32: store data.
- `requested_data_to_mem` output 1: stall; high whenever FSM ≠ IDLE.
- `readdata` output 32: load data, registered.
- `rdata_valid` output 1: one-cycle pulse when `readdata` carries a completed load.
- `mm_req` output 1: main-memory request, held until `mm_ack`.
- `mm_we` output 1: 1 = line write-back, 0 = line fetch.
- `mm_addr` output 32: line-aligned address (`[3:0]`=0).
- `mm_wline` output 128: evicted line, word 0 in `[31:0]`.
- `mm_rline` input 128: refill line, valid with `mm_ack`.
- `mm_ack` input 1: one-cycle completion; ignored unless `mm_req`=1.

## Operation
- Per-line state: valid, dirty, tag, 4 data words.
- FSM states: IDLE, EVICT, REFILL, COMPLETE.
- IDLE, no request: nothing changes.
- IDLE, hit (valid && tag match):
  - Read: `readdata` <= word; `rdata_valid` <= 1.
  - Write: word <= `writedata`; dirty <= 1.
  - Read+write together: write first; `readdata` <= `writedata`; `rdata_valid` <= 1.
  - FSM stays in IDLE; no stall.
- IDLE, miss:
  - Latch read, write, address and writedata.
  - Victim valid && dirty: go to EVICT. `mm_req`=1, `mm_we`=1, `mm_addr`={victim tag, index, 4'b0}, `mm_wline`=victim data.
  - Otherwise: go to REFILL.
- EVICT, on `mm_ack`: go to REFILL.
- REFILL: `mm_req`=1, `mm_we`=0, `mm_addr`={latched tag, index, 4'b0}.
- REFILL, on `mm_ack`: line <= `mm_rline`; valid <= 1; dirty <= 0; tag <= latched tag; go to COMPLETE.
- COMPLETE: apply the latched operation to the line using the hit rules, then go to IDLE.
- Request inputs are ignored outside IDLE.
- `mm_ack` while `mm_req`=0 is ignored.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - All valid and dirty bits 0. Data and tag contents are don't-care.
- Hit: request sampled at edge N; `readdata`/`rdata_valid` visible after edge N. Zero stall cycles.
- Miss:
  - Stall rises after edge N.
  - `mm_req` rises after edge N, or immediately after EVICT→REFILL without a low cycle between transactions.
  - `mm_req` falls after the edge that samples `mm_ack`.
  - Refill ack at edge M: COMPLETE after M; data, `rdata_valid` and stall=0 after edge M+1.
- Clean miss with ack 1 cycle after `mm_req` rises: 3 stall cycles.
- Reset at any point, including mid-EVICT/REFILL:
  - Abandons the transaction; `mm_req`=0 after the reset edge.
  - Dirty data is discarded.
  - Main memory must tolerate an abandoned request.
- Reset takes priority over every other event.

## Configuration
- `DCACHE_STATS_EN` defined: adds output ports `hit_count` [31:0] and `miss_count` [31:0].
  - Each increments by 1 per accepted IDLE request that hits or misses, respectively.
  - Both clear on reset; both wrap at 2^32.
- Not defined: the ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then read 0x0:
  - Stall=1; `mm_req`=1, `mm_we`=0, `mm_addr`=0x0.
  - Ack with `mm_rline`={0x33,0x22,0x11,0x00}: `readdata`=0x00.
  - Read 0x4 next: `readdata`=0x11 with no stall.
- Write 0x8 with data 0x5 (hit): no stall, no `mm_req`. Then read 0x8: `readdata`=0x5.
- Read 0x40 (index 0, dirty victim):
  - EVICT: `mm_we`=1, `mm_addr`=0x0, `mm_wline[95:64]`=0x5.
  - Then REFILL: `mm_addr`=0x40.
  - Completes with the refilled word.
- Simultaneous read+write to 0x54 with data 0xAB (miss):
  - After refill, `readdata`=0xAB.
  - A later read of 0x54 returns 0xAB.
  - Evicting this line writes 0xAB back.
- Assert reset during REFILL:
  - `mm_req`=0 and stall=0 after the reset edge.
  - Re-reading 0x0 misses again.
- With `DCACHE_STATS_EN`, run the sequence miss, hit, hit, miss: `hit_count`=2, `miss_count`=2. Reset clears both to 0.

Source files
------------

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache with a req/ack line port.
// Optional DCACHE_STATS_EN adds hit_count/miss_count outputs.
module dcache_responder #(
  parameter int LINES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  address,
  input  logic [31:0]  writedata,
  output logic         requested_data_to_mem,
  output logic [31:0]  readdata,
  output logic         rdata_valid,
  output logic         mm_req,
  output logic         mm_we,
  output logic [31:0]  mm_addr,
  output logic [127:0] mm_wline,
  input  logic [127:0] mm_rline,
  input  logic         mm_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVICT,
    S_REFILL,
    S_COMPLETE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TW-1:0]    r_tag  [LINES];
  logic [127:0]     r_line [LINES];

  logic             r_rd;
  logic             r_wr;
  logic [31:2]      r_addr;
  logic [31:0]      r_wdata;

  logic [IW-1:0]    w_idx;
  logic [TW-1:0]    w_tag;
  logic [1:0]       w_word;
  logic [IW-1:0]    w_ridx;
  logic [TW-1:0]    w_rtag;
  logic [1:0]       w_rword;
  logic             w_req;
  logic             w_hit;
  logic             w_hit_acc;
  logic             w_miss_acc;
  logic             w_cmp;
  logic             w_fill;
  logic [IW-1:0]    w_op_idx;
  logic [1:0]       w_op_word;
  logic             w_op_wr;
  logic             w_op_rd;
  logic [31:0]      w_op_data;
  logic [31:0]      w_cur_word;
  logic             w_unused_addr;

  assign w_idx   = address[4 +: IW];
  assign w_tag   = address[31 -: TW];
  assign w_word  = address[3:2];
  assign w_ridx  = r_addr[4 +: IW];
  assign w_rtag  = r_addr[31 -: TW];
  assign w_rword = r_addr[3:2];

  assign w_unused_addr = ^address[1:0];

  assign w_req      = mem_read | mem_write;
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit_acc  = (r_state == S_IDLE) && w_req && w_hit;
  assign w_miss_acc = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_cmp      = (r_state == S_COMPLETE);
  assign w_fill     = (r_state == S_REFILL) && mm_ack;

  // A hit and the COMPLETE replay share one access path
  assign w_op_idx   = w_cmp ? w_ridx  : w_idx;
  assign w_op_word  = w_cmp ? w_rword : w_word;
  assign w_op_data  = w_cmp ? r_wdata : writedata;
  assign w_op_wr    = w_cmp ? r_wr : (w_hit_acc && mem_write);
  assign w_op_rd    = w_cmp ? r_rd : (w_hit_acc && mem_read);
  assign w_cur_word = r_line[w_op_idx][{w_op_word, 5'b0} +: 32];

  assign requested_data_to_mem = (r_state != S_IDLE);

  always_comb begin
    w_next   = r_state;
    mm_req   = 1'b0;
    mm_we    = 1'b0;
    mm_addr  = '0;
    mm_wline = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_miss_acc) begin
          if (r_valid[w_idx] && r_dirty[w_idx]) begin
            w_next = S_EVICT;
          end else begin
            w_next = S_REFILL;
          end
        end
      end
      S_EVICT: begin
        mm_req   = 1'b1;
        mm_we    = 1'b1;
        mm_addr  = {r_tag[w_ridx], w_ridx, 4'b0};
        mm_wline = r_line[w_ridx];
        if (mm_ack) begin
          w_next = S_REFILL;
        end
      end
      S_REFILL: begin
        mm_req  = 1'b1;
        mm_addr = {w_rtag, w_ridx, 4'b0};
        if (mm_ack) begin
          w_next = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      readdata    <= '0;
      rdata_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      rdata_valid <= w_op_rd;
      if (w_op_rd) begin
        readdata <= w_op_wr ? w_op_data : w_cur_word;
      end
      if (w_op_wr) begin
        r_dirty[w_op_idx] <= 1'b1;
      end
      if (w_miss_acc) begin
        r_rd    <= mem_read;
        r_wr    <= mem_write;
        r_addr  <= address[31:2];
        r_wdata <= writedata;
      end
      if (w_fill) begin
        r_valid[w_ridx] <= 1'b1;
        r_dirty[w_ridx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays need no reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_fill) begin
        r_line[w_ridx] <= mm_rline;
        r_tag[w_ridx]  <= w_rtag;
      end
      if (w_op_wr) begin
        r_line[w_op_idx][{w_op_word, 5'b0} +: 32] <= w_op_data;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (w_hit_acc) begin
        hit_count <= hit_count + 32'd1;
      end
      if (w_miss_acc) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a 1-cycle-ack main-memory model.
// Vector table covers hits, clean/dirty misses; hand sequences cover reset and stats.
module tb_dcache_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic         requested_data_to_mem;
  logic [31:0]  readdata;
  logic         rdata_valid;
  logic         mm_req;
  logic         mm_we;
  logic [31:0]  mm_addr;
  logic [127:0] mm_wline;
  logic [127:0] mm_rline;
  logic         mm_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  always #5 clk = ~clk;

  dcache_responder #(.LINES(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .mem_read              (mem_read),
    .mem_write             (mem_write),
    .address               (address),
    .writedata             (writedata),
    .requested_data_to_mem (requested_data_to_mem),
    .readdata              (readdata),
    .rdata_valid           (rdata_valid),
    .mm_req                (mm_req),
    .mm_we                 (mm_we),
    .mm_addr               (mm_addr),
    .mm_wline              (mm_wline),
    .mm_rline              (mm_rline),
    .mm_ack                (mm_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count             (hit_count),
    .miss_count            (miss_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  int           ev_cnt = 0;
  logic [31:0]  ev_addr;
  logic [127:0] ev_line;
  int           fe_cnt = 0;
  logic [31:0]  fe_addr;
  logic         hold = 1'b0;
  int           cnt = 0;

  function automatic logic [127:0] pat(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'b0};
    return {b + 32'h33, b + 32'h22, b + 32'h11, b};
  endfunction

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Main memory: acks one cycle after it first sees mm_req
  initial begin
    mm_ack   = 1'b0;
    mm_rline = '0;
    forever begin
      @(negedge clk);
      if (mm_ack) begin
        mm_ack = 1'b0;
        cnt    = (mm_req && !hold) ? 1 : 0;
      end else if (mm_req && !hold) begin
        if (cnt >= 1) begin
          mm_ack   = 1'b1;
          mm_rline = pat(mm_addr);
          if (mm_we) begin
            ev_cnt++;
            ev_addr = mm_addr;
            ev_line = mm_wline;
          end else begin
            fe_cnt++;
            fe_addr = mm_addr;
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] rdata;
    logic        ev;
    logic [31:0] ev_addr;
    int          ev_w;
    logic [31:0] ev_word;
    logic [31:0] fe_addr;
  } vec_t;

  vec_t vt [16];

  task automatic do_op(input vec_t v);
    int ev0;
    int fc0;
    int st;
    ev0 = ev_cnt;
    fc0 = fe_cnt;
    st  = 0;
    @(negedge clk);
    mem_read  = v.rd;
    mem_write = v.wr;
    address   = v.addr;
    writedata = v.wdata;
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (v.stall == 0) check("hit_no_mmreq", mm_req, 0);
    while (requested_data_to_mem && st < 40) begin
      st++;
      @(posedge clk);
      #1;
    end
    check("stall_cycles", st, v.stall);
    check("rdata_valid", rdata_valid, v.rd);
    if (v.rd) check("readdata", readdata, v.rdata);
    check("evict_count", ev_cnt - ev0, v.ev);
    if (v.ev) begin
      check("evict_addr", ev_addr, v.ev_addr);
      check("evict_word", ev_line[v.ev_w*32 +: 32], v.ev_word);
    end
    if (v.stall > 0) begin
      check("fetch_count", fe_cnt - fc0, 1);
      check("fetch_addr", fe_addr, v.fe_addr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_stall", requested_data_to_mem, 0);
    check("rst_mm_req", mm_req, 0);
    check("rst_mm_we", mm_we, 0);
    check("rst_mm_addr", mm_addr, 0);
    check("rst_mm_wline", mm_wline, 0);
    check("rst_rvalid", rdata_valid, 0);
    check("rst_readdata", readdata, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t rv;
    reset     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    address   = '0;
    writedata = '0;

    vt[0]  = '{1, 0, 32'h00, 32'h0,    3, 32'h00,   0, 32'h0,  0, 32'h0,  32'h00};
    vt[1]  = '{1, 0, 32'h04, 32'h0,    0, 32'h11,   0, 32'h0,  0, 32'h0,  32'h0};
    vt[2]  = '{0, 1, 32'h08, 32'h5,    0, 32'h0,    0, 32'h0,  0, 32'h0,  32'h0};
    vt[3]  = '{1, 0, 32'h08, 32'h0,    0, 32'h5,    0, 32'h0,  0, 32'h0,  32'h0};
    vt[4]  = '{1, 0, 32'h40, 32'h0,    5, 32'h40,   1, 32'h00, 2, 32'h5,  32'h40};
    vt[5]  = '{1, 1, 32'h54, 32'hAB,   3, 32'hAB,   0, 32'h0,  0, 32'h0,  32'h50};
    vt[6]  = '{1, 0, 32'h54, 32'h0,    0, 32'hAB,   0, 32'h0,  0, 32'h0,  32'h0};
    vt[7]  = '{1, 0, 32'h50, 32'h0,    0, 32'h50,   0, 32'h0,  0, 32'h0,  32'h0};
    vt[8]  = '{1, 0, 32'h14, 32'h0,    5, 32'h21,   1, 32'h50, 1, 32'hAB, 32'h10};
    vt[9]  = '{0, 1, 32'h7C, 32'hDEAD, 3, 32'h0,    0, 32'h0,  0, 32'h0,  32'h70};
    vt[10] = '{1, 0, 32'h7C, 32'h0,    0, 32'hDEAD, 0, 32'h0,  0, 32'h0,  32'h0};
    vt[11] = '{1, 0, 32'h4C, 32'h0,    0, 32'h73,   0, 32'h0,  0, 32'h0,  32'h0};
    vt[12] = '{1, 0, 32'h00, 32'h0,    3, 32'h00,   0, 32'h0,  0, 32'h0,  32'h00};
    vt[13] = '{1, 1, 32'h04, 32'h77,   0, 32'h77,   0, 32'h0,  0, 32'h0,  32'h0};
    vt[14] = '{1, 0, 32'h04, 32'h0,    0, 32'h77,   0, 32'h0,  0, 32'h0,  32'h0};
    vt[15] = '{1, 0, 32'h0C, 32'h0,    0, 32'h33,   0, 32'h0,  0, 32'h0,  32'h0};

    do_reset();

    // First miss: check the fetch request while stalled
    @(negedge clk);
    mem_read = 1'b1;
    address  = 32'h0;
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    check("miss_stall", requested_data_to_mem, 1);
    check("miss_mm_req", mm_req, 1);
    check("miss_mm_we", mm_we, 0);
    check("miss_mm_addr", mm_addr, 32'h0);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      do_op(vt[i]);
    end

    // Reset while REFILL is waiting on memory
    hold = 1'b1;
    @(negedge clk);
    mem_read = 1'b1;
    address  = 32'h20;
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    check("hold_mm_req", mm_req, 1);
    check("hold_mm_addr", mm_addr, 32'h20);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_mm_req", mm_req, 0);
    check("midrst_stall", requested_data_to_mem, 0);
    @(negedge clk);
    reset = 1'b0;
    hold  = 1'b0;
    rv = '{1, 0, 32'h00, 32'h0, 3, 32'h00, 0, 32'h0, 0, 32'h0, 32'h00};
    do_op(rv);

`ifdef DCACHE_STATS_EN
    do_reset();
    check("stats_rst_hit", hit_count, 0);
    check("stats_rst_miss", miss_count, 0);
    do_op(rv);
    rv = '{1, 0, 32'h00, 32'h0, 0, 32'h00, 0, 32'h0, 0, 32'h0, 32'h0};
    do_op(rv);
    rv = '{1, 0, 32'h04, 32'h0, 0, 32'h11, 0, 32'h0, 0, 32'h0, 32'h0};
    do_op(rv);
    rv = '{1, 0, 32'h40, 32'h0, 3, 32'h40, 0, 32'h0, 0, 32'h0, 32'h40};
    do_op(rv);
    check("stats_hit", hit_count, 2);
    check("stats_miss", miss_count, 2);
    do_reset();
    check("stats_clr_hit", hit_count, 0);
    check("stats_clr_miss", miss_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
